// File: rtl/seq_shifter.sv
// seq_shifter: loads an operand, then shifts or rotates it one bit per clock for SHAMT cycles.
// Optional carry/zero flags are enabled with the SEQ_SHIFTER_FLAGS_EN macro.
module seq_shifter #(
   parameter int DATAWIDTH = 8,
   parameter int SHWIDTH   = 3
) (
   input  logic                 CLK,
   input  logic                 RESET_N,
   input  logic                 START,
   input  logic [2:0]           OP,
   input  logic [SHWIDTH-1:0]   SHAMT,
   input  logic                 SIN,
   input  logic [DATAWIDTH-1:0] D,
   output logic [DATAWIDTH-1:0] Q,
   output logic                 BUSY,
   output logic                 DONE
`ifdef SEQ_SHIFTER_FLAGS_EN
   ,
   output logic                 COUT,
   output logic                 ZERO
`endif
);

   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_FIN} state_t;

   localparam logic [2:0] OP_SLL = 3'b000;
   localparam logic [2:0] OP_SRL = 3'b001;
   localparam logic [2:0] OP_SRA = 3'b010;
   localparam logic [2:0] OP_ROL = 3'b011;
   localparam logic [2:0] OP_ROR = 3'b100;

   state_t               state_q, state_d;
   logic [DATAWIDTH-1:0] q_q, q_d;
   logic [SHWIDTH-1:0]   count_q, count_d;
   logic [2:0]           op_q, op_d;
   logic                 sin_q, sin_d;
   logic [DATAWIDTH-1:0] step_val;

   // One-bit step of the latched operation applied to the working register.
   always_comb begin
      case (op_q)
         OP_SLL:  step_val = {q_q[DATAWIDTH-2:0], sin_q};
         OP_SRL:  step_val = {sin_q, q_q[DATAWIDTH-1:1]};
         OP_SRA:  step_val = {q_q[DATAWIDTH-1], q_q[DATAWIDTH-1:1]};
         OP_ROL:  step_val = {q_q[DATAWIDTH-2:0], q_q[DATAWIDTH-1]};
         OP_ROR:  step_val = {q_q[0], q_q[DATAWIDTH-1:1]};
         default: step_val = q_q;
      endcase
   end

`ifdef SEQ_SHIFTER_FLAGS_EN
   logic cout_q, cout_d;
   logic step_out;

   // Left-going steps shed the MSB; right-going steps shed the LSB.
   always_comb begin
      case (op_q)
         OP_SLL, OP_ROL: step_out = q_q[DATAWIDTH-1];
         OP_SRL, OP_SRA, OP_ROR: step_out = q_q[0];
         default: step_out = 1'b0;
      endcase
   end
`endif

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can infer a latch.
      state_d = state_q;
      q_d     = q_q;
      count_d = count_q;
      op_d    = op_q;
      sin_d   = sin_q;
`ifdef SEQ_SHIFTER_FLAGS_EN
      cout_d  = cout_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (START) begin
               q_d     = D;
               op_d    = OP;
               sin_d   = SIN;
               count_d = SHAMT;
`ifdef SEQ_SHIFTER_FLAGS_EN
               cout_d  = 1'b0;
`endif
               // Codes above ROR are plain loads and skip the shift phase.
               if (SHAMT == '0 || OP > OP_ROR) state_d = ST_FIN;
               else                            state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            q_d     = step_val;
            count_d = count_q - 1'b1;
`ifdef SEQ_SHIFTER_FLAGS_EN
            cout_d  = step_out;
`endif
            if (count_q == SHWIDTH'(1)) state_d = ST_FIN;
         end
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= ST_IDLE;
         q_q     <= '0;
         count_q <= '0;
         op_q    <= '0;
         sin_q   <= 1'b0;
`ifdef SEQ_SHIFTER_FLAGS_EN
         cout_q  <= 1'b0;
`endif
      end else begin
         // NOTE: sequential state uses non-blocking assignment so all flops update together.
         state_q <= state_d;
         q_q     <= q_d;
         count_q <= count_d;
         op_q    <= op_d;
         sin_q   <= sin_d;
`ifdef SEQ_SHIFTER_FLAGS_EN
         cout_q  <= cout_d;
`endif
      end
   end

   assign Q    = q_q;
   assign BUSY = (state_q == ST_SHIFT);
   assign DONE = (state_q == ST_FIN);
`ifdef SEQ_SHIFTER_FLAGS_EN
   assign COUT = cout_q;
   assign ZERO = (q_q == '0);
`endif

endmodule
